// File: rtl/imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl
//
// Owns a 256 x 8 single-port instruction memory (write-enabled, combinational
// read) and sequences it between program loading and CPU instruction fetch.
//
//   LOAD   : loader bytes are written to consecutive addresses (CPU stalled)
//   FILL   : the unused tail of the memory is zero-filled up to address 255
//   VECTOR : MEM[0] is read and captured as the boot PC
//   RUN    : CPU fetch address passes straight through; RELOAD restarts LOAD
//
// Ports
//   CLK, RST              clock; asynchronous active-low reset
//   LD_VALID/DATA/LAST    loader byte stream; LD_READY = byte accepted
//   RELOAD                request a new program load (honoured only in RUN)
//   PC / INSTR            CPU fetch address / instruction (combinational)
//   CPU_STALL             CPU must hold its PC and pipeline
//   BOOT_PC / BOOT_VALID  start address and its one-cycle load strobe
//   LOAD_CNT              bytes accepted by the current/last load (0..256)
//   OVF                   sticky: 256 bytes accepted without LD_LAST
//   MEM_A/WD/WE, MEM_RD   instruction memory port
// -----------------------------------------------------------------------------
module imem_boot_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD_VALID,
  input  logic [7:0] LD_DATA,
  input  logic       LD_LAST,
  output logic       LD_READY,
  input  logic       RELOAD,
  input  logic [7:0] PC,
  output logic [7:0] INSTR,
  output logic       CPU_STALL,
  output logic [7:0] BOOT_PC,
  output logic       BOOT_VALID,
  output logic [8:0] LOAD_CNT,
  output logic       OVF,
  output logic [7:0] MEM_A,
  output logic [7:0] MEM_WD,
  output logic       MEM_WE,
  input  logic [7:0] MEM_RD
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_FILL   = 2'd1,
    S_VECTOR = 2'd2,
    S_RUN    = 2'd3
  } state_e;

  state_e     state_q,      state_d;
  logic [7:0] wr_ptr_q,     wr_ptr_d;
  logic [8:0] load_cnt_q,   load_cnt_d;
  logic       ovf_q,        ovf_d;
  logic [7:0] boot_pc_q,    boot_pc_d;
  logic       boot_valid_q, boot_valid_d;

  logic       accept;

  // ---------------------------------------------------------------------------
  // Memory port and CPU-facing outputs. While RST is low the state register is
  // already forced to LOAD with wr_ptr=0, so only the handshake and the write
  // strobe need explicit gating to stay quiet during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    LD_READY  = 1'b0;
    CPU_STALL = 1'b1;
    INSTR     = 8'h00;
    MEM_A     = 8'h00;
    MEM_WD    = 8'h00;
    MEM_WE    = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        LD_READY = RST;
        MEM_A    = wr_ptr_q;
        MEM_WD   = LD_DATA;
        MEM_WE   = RST & LD_VALID;
      end
      S_FILL: begin
        MEM_A  = wr_ptr_q;
        MEM_WE = RST;
      end
      S_VECTOR: begin
        MEM_A = 8'h00;
      end
      S_RUN: begin
        MEM_A     = PC;
        INSTR     = MEM_RD;
        CPU_STALL = 1'b0;
      end
      default: ;
    endcase
  end

  assign accept = LD_VALID & LD_READY;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    load_cnt_d   = load_cnt_q;
    ovf_d        = ovf_q;
    boot_pc_d    = boot_pc_q;
    boot_valid_d = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          wr_ptr_d   = wr_ptr_q + 8'd1;
          load_cnt_d = load_cnt_q + 9'd1;
          // The last address has been written: the memory is full whether or
          // not the loader flagged the end, so no fill is needed.
          if (wr_ptr_q == 8'hFF) begin
            state_d = S_VECTOR;
            if (!LD_LAST) ovf_d = 1'b1;
          end else if (LD_LAST) begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        wr_ptr_d = wr_ptr_q + 8'd1;
        if (wr_ptr_q == 8'hFF) state_d = S_VECTOR;
      end
      S_VECTOR: begin
        boot_pc_d    = MEM_RD;
        boot_valid_d = 1'b1;
        state_d      = S_RUN;
      end
      S_RUN: begin
        // BOOT_VALID may be high in this same cycle; the reload still wins.
        if (RELOAD) begin
          state_d    = S_LOAD;
          wr_ptr_d   = 8'h00;
          load_cnt_d = 9'd0;
          ovf_d      = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. The memory array lives outside this block and is not
  // reset; every load rewrites all 256 locations instead.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_LOAD;
      wr_ptr_q     <= 8'h00;
      load_cnt_q   <= 9'd0;
      ovf_q        <= 1'b0;
      boot_pc_q    <= 8'h00;
      boot_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      load_cnt_q   <= load_cnt_d;
      ovf_q        <= ovf_d;
      boot_pc_q    <= boot_pc_d;
      boot_valid_q <= boot_valid_d;
    end
  end

  assign LOAD_CNT   = load_cnt_q;
  assign OVF        = ovf_q;
  assign BOOT_PC    = boot_pc_q;
  assign BOOT_VALID = boot_valid_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_ctrl
//
// Self-checking bench for imem_boot_ctrl with a behavioural 256 x 8 memory.
// Expected memory images, boot PC, byte counts, overflow and phase lengths are
// derived from the program bytes handed to each load.
// -----------------------------------------------------------------------------
module tb_imem_boot_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LD_VALID, LD_LAST, LD_READY, RELOAD;
  logic [7:0] LD_DATA, PC, INSTR, BOOT_PC, MEM_A, MEM_WD, MEM_RD;
  logic       CPU_STALL, BOOT_VALID, OVF, MEM_WE;
  logic [8:0] LOAD_CNT;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  imem_boot_ctrl dut (
    .CLK(CLK), .RST(RST),
    .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_READY(LD_READY),
    .RELOAD(RELOAD), .PC(PC), .INSTR(INSTR), .CPU_STALL(CPU_STALL),
    .BOOT_PC(BOOT_PC), .BOOT_VALID(BOOT_VALID), .LOAD_CNT(LOAD_CNT), .OVF(OVF),
    .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
  );

  // Behavioural instruction memory: synchronous write, combinational read.
  logic [7:0] mem [256];
  assign MEM_RD = mem[MEM_A];
  always @(posedge CLK) if (MEM_WE) mem[MEM_A] <= MEM_WD;

  // Image the memory should hold after the most recent completed load.
  logic [7:0] img [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag, input logic [7:0] exp_wd);
    check({tag, "_ld_ready"},   LD_READY,   0);
    check({tag, "_mem_we"},     MEM_WE,     0);
    check({tag, "_cpu_stall"},  CPU_STALL,  1);
    check({tag, "_instr"},      INSTR,      0);
    check({tag, "_mem_a"},      MEM_A,      0);
    check({tag, "_mem_wd"},     MEM_WD,     exp_wd);
    check({tag, "_boot_pc"},    BOOT_PC,    0);
    check({tag, "_boot_valid"}, BOOT_VALID, 0);
    check({tag, "_load_cnt"},   LOAD_CNT,   0);
    check({tag, "_ovf"},        OVF,        0);
  endtask

  // Drives one complete program load starting in LOAD and stops one cycle
  // after the BOOT_VALID strobe. Expectations come from the program alone:
  // accepted bytes = min(size, 256), zero tail, FILL length 256-N, one VECTOR
  // cycle, and RUN starting right after it.
  task automatic run_load(input logic [7:0] prog [$], input bit last, input int gap_pct,
                          input bit noise, input bit reload_at_boot, input string tag);
    int  n_acc, fill_exp, idx, fills, wd_bad, gaps, cyc, last_acc_cyc, done_cyc, k, bad;
    bit  done, ovf_exp;
    n_acc    = (prog.size() > 256) ? 256 : prog.size();
    fill_exp = (n_acc < 256) ? 256 - n_acc : 0;
    ovf_exp  = (n_acc == 256) && !(last && prog.size() == 256);
    for (int i = 0; i < 256; i++) img[i] = (i < n_acc) ? prog[i] : 8'h00;

    idx = 0; fills = 0; wd_bad = 0; gaps = 0; cyc = 0;
    last_acc_cyc = -1; done_cyc = -1; done = 0;
    while (!done && cyc < 3000) begin
      k = (idx < n_acc) ? 0 : cyc - last_acc_cyc;
      if (idx < n_acc) begin
        if ($urandom_range(99) >= gap_pct) begin
          LD_VALID = 1'b1;
          LD_DATA  = prog[idx];
          LD_LAST  = last && (idx == prog.size() - 1);
        end else begin
          LD_VALID = 1'b0;
          LD_DATA  = 8'($urandom);
          LD_LAST  = 1'($urandom);
          gaps++;
        end
      end else begin
        // Stray loader traffic after the program must be ignored.
        LD_VALID = 1'($urandom);
        LD_DATA  = 8'($urandom);
        LD_LAST  = 1'($urandom);
      end
      RELOAD = 1'b0;
      if (noise && k <= fill_exp) RELOAD = 1'($urandom);
      if (reload_at_boot && idx >= n_acc && k == fill_exp + 2) RELOAD = 1'b1;

      @(negedge CLK);
      if (LD_VALID && LD_READY) begin
        idx++;
        if (idx == n_acc) last_acc_cyc = cyc;
      end
      if (MEM_WE && !LD_READY) begin
        fills++;
        if (MEM_WD !== 8'h00) wd_bad++;
      end
      if (BOOT_VALID) begin
        done     = 1;
        done_cyc = cyc;
        check({tag, "_boot_pc"},   BOOT_PC,   img[0]);
        check({tag, "_load_cnt"},  LOAD_CNT,  n_acc);
        check({tag, "_ovf"},       OVF,       ovf_exp);
        check({tag, "_run_stall"}, CPU_STALL, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) bad++;
        check({tag, "_image_bad_bytes"}, bad, 0);
      end
      next_cycle();
      cyc++;
    end
    RELOAD   = 1'b0;
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;

    check({tag, "_boot_seen"},    done,         1);
    check({tag, "_accepted"},     idx,          n_acc);
    check({tag, "_fill_cycles"},  fills,        fill_exp);
    check({tag, "_fill_wd_zero"}, wd_bad,       0);
    check({tag, "_load_cycles"},  last_acc_cyc, n_acc - 1 + gaps);
    check({tag, "_vector_lat"},   done_cyc,     last_acc_cyc + fill_exp + 2);

    @(negedge CLK);
    check({tag, "_boot_pulse"}, BOOT_VALID, 0);
    if (reload_at_boot) begin
      check({tag, "_rl_stall"},    CPU_STALL, 1);
      check({tag, "_rl_ready"},    LD_READY,  1);
      check({tag, "_rl_load_cnt"}, LOAD_CNT,  0);
    end else begin
      check({tag, "_stay_run"}, CPU_STALL, 0);
    end
    next_cycle();
  endtask

  task automatic do_reload(input string tag);
    LD_VALID = 1'b0;
    RELOAD   = 1'b1;
    PC       = 8'($urandom);
    @(negedge CLK);
    check({tag, "_pre_stall"}, CPU_STALL, 0);
    next_cycle();
    RELOAD = 1'b0;
    @(negedge CLK);
    check({tag, "_stall"},    CPU_STALL, 1);
    check({tag, "_load_cnt"}, LOAD_CNT,  0);
    check({tag, "_ovf"},      OVF,       0);
    check({tag, "_ready"},    LD_READY,  1);
    check({tag, "_instr"},    INSTR,     0);
    next_cycle();
  endtask

  typedef struct {
    logic [7:0] pc;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic [7:0] exp_instr;
  } fetch_vec_t;

  initial begin
    fetch_vec_t tbl [6];
    logic [7:0] q [$];
    bit found;
    int bad, size;

    tbl[0] = '{8'h00, 1'b0, 8'h00, 8'h10};
    tbl[1] = '{8'h01, 1'b0, 8'h00, 8'hA5};
    tbl[2] = '{8'h02, 1'b1, 8'hEE, 8'h3C};
    tbl[3] = '{8'h03, 1'b1, 8'hFF, 8'h00};
    tbl[4] = '{8'hFF, 1'b1, 8'h77, 8'h00};
    tbl[5] = '{8'h00, 1'b1, 8'h11, 8'h10};

    RST = 1'b0; LD_VALID = 1'b1; LD_DATA = 8'h5A; LD_LAST = 1'b0;
    RELOAD = 1'b0; PC = 8'h00;
    #12;
    check_reset_vals("reset", 8'h5A);
    LD_VALID = 1'b0;
    next_cycle();
    RST = 1'b1;

    // Three-byte program, gapless.
    q = '{8'h10, 8'hA5, 8'h3C};
    run_load(q, 1, 0, 0, 0, "load3");

    // Fetch table in RUN; loader traffic must not touch the memory.
    for (int i = 0; i < 6; i++) begin
      PC = tbl[i].pc; LD_VALID = tbl[i].ld_valid; LD_DATA = tbl[i].ld_data;
      @(negedge CLK);
      check($sformatf("fetch%0d_instr", i), INSTR,     tbl[i].exp_instr);
      check($sformatf("fetch%0d_mem_a", i), MEM_A,     tbl[i].pc);
      check($sformatf("fetch%0d_we", i),    MEM_WE,    0);
      check($sformatf("fetch%0d_ready", i), LD_READY,  0);
      next_cycle();
    end
    LD_VALID = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) bad++;
    check("run_ld_valid_mem_unchanged", bad, 0);

    // Full 256-byte stream without LAST: overflow, no fill.
    do_reload("reload_a");
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(8'(i) ^ 8'h55);
    run_load(q, 0, 0, 0, 0, "ovf256");

    // Single byte, then reload and a two-byte program.
    do_reload("reload_b");
    q = '{8'h07};
    run_load(q, 1, 0, 0, 0, "load1");
    do_reload("reload_c");
    q = '{8'h20, 8'h99};
    run_load(q, 1, 0, 0, 0, "load2");

    // RELOAD coinciding with the BOOT_VALID cycle takes effect.
    do_reload("reload_d");
    q = '{8'h33, 8'h44};
    run_load(q, 1, 0, 0, 1, "boot_reload");

    // Gappy loader with RELOAD noise during LOAD/FILL.
    q = '{8'h40, 8'h01, 8'h02};
    run_load(q, 1, 35, 1, 0, "gappy");

    // Reset in the middle of FILL.
    do_reload("reload_e");
    LD_VALID = 1'b1; LD_DATA = 8'h07; LD_LAST = 1'b1;
    next_cycle();
    LD_VALID = 1'b0; LD_LAST = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge CLK);
      if (MEM_A == 8'h80 && MEM_WE && !LD_READY) found = 1;
      else next_cycle();
    end
    check("midfill_reached", found, 1);
    #2;
    LD_VALID = 1'b1; LD_DATA = 8'hA7;
    RST = 1'b0;
    #1;
    check_reset_vals("midfill_rst", 8'hA7);
    next_cycle();
    check("midfill_rst_we_hold", MEM_WE, 0);
    LD_VALID = 1'b0;
    RST = 1'b1;
    q = '{8'hC3, 8'h5E, 8'h00, 8'hFF, 8'h81};
    run_load(q, 1, 0, 0, 0, "recover");

    // Randomized programs with random fetches in RUN.
    for (int t = 0; t < 4; t++) begin
      do_reload($sformatf("rnd%0d_reload", t));
      size = $urandom_range(256, 1);
      q.delete();
      for (int i = 0; i < size; i++) q.push_back(8'($urandom));
      run_load(q, (size < 256) ? 1'b1 : 1'($urandom), $urandom_range(40), 1, 0,
               $sformatf("rnd%0d", t));
      for (int f = 0; f < 10; f++) begin
        PC = 8'($urandom);
        @(negedge CLK);
        check($sformatf("rnd%0d_fetch%0d", t, f), INSTR, img[PC]);
        next_cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot/load controller that owns the single-port 8-bit instruction memory (write-enabled variant, 256 x 8, combinational read) and sequences it between a program-load byte stream and CPU instruction fetch. After reset it holds the CPU stalled, writes incoming bytes to consecutive addresses and zero-fills the unused tail. It then reads the boot vector from address 0 and releases the CPU with that start PC. In RUN it passes the CPU fetch address straight through to the memory.

## Interface
- No parameters; memory depth fixed at 256, data width fixed at 8.
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  asynchronous active-low reset
- LD_VALID  in  1  loader byte valid
- LD_DATA  in  8  loader byte
- LD_LAST  in  1  marks final byte of program; qualified by LD_VALID
- LD_READY  out  1  controller accepts a byte this cycle
- RELOAD  in  1  request new program load; sampled only in RUN
- PC  in  8  CPU fetch address
- INSTR  out  8  fetched instruction to CPU
- CPU_STALL  out  1  CPU must hold PC and pipeline
- BOOT_PC  out  8  registered start address (contents of MEM[0] at boot)
- BOOT_VALID  out  1  one-cycle pulse: CPU loads BOOT_PC into its PC
- LOAD_CNT  out  9  bytes accepted in the current/last load (0..256)
- OVF  out  1  sticky: 256 bytes accepted without LD_LAST
- MEM_A  out  8  memory address
- MEM_WD  out  8  memory write data
- MEM_WE  out  1  memory write enable (memory writes on CLK rising edge)
- MEM_RD  in  8  memory combinational read data

## Operation
- States: LOAD, FILL, VECTOR, RUN. Reset state LOAD.
- Registers: wr_ptr[7:0], LOAD_CNT, OVF, BOOT_PC, BOOT_VALID.
- LOAD: LD_READY=1, CPU_STALL=1, MEM_A=wr_ptr, MEM_WD=LD_DATA, MEM_WE=LD_VALID.
  - On accept (LD_VALID and LD_READY): wr_ptr+1 (8-bit wrap), LOAD_CNT+1.
  - Accept with LD_LAST and wr_ptr<255 -> FILL, with wr_ptr advanced.
  - Accept with wr_ptr=255: go to VECTOR. If LD_LAST=0, set OVF; no implicit continuation. Later bytes are not accepted.
  - No LD_VALID: hold indefinitely, no timeout.
- FILL: LD_READY=0, CPU_STALL=1, MEM_A=wr_ptr, MEM_WD=0, MEM_WE=1. wr_ptr+1 each cycle; after writing address 255 -> VECTOR.
- VECTOR: CPU_STALL=1, MEM_WE=0, MEM_A=0. BOOT_PC<=MEM_RD, BOOT_VALID<=1 -> RUN.
- RUN: MEM_A=PC, MEM_WE=0, INSTR=MEM_RD (combinational), CPU_STALL=0, LD_READY=0. BOOT_VALID high only in the first RUN cycle.
  - RELOAD=1 -> LOAD next cycle; clear wr_ptr, LOAD_CNT and OVF on that edge.
- RELOAD outside RUN is ignored. LD_VALID outside LOAD is ignored and never written.
- INSTR=0 in every state except RUN.

## Timing
- Reset (RST low, async): state=LOAD, wr_ptr=0, LOAD_CNT=0, OVF=0, BOOT_PC=0, BOOT_VALID=0.
  - While RST is low, LD_READY and MEM_WE are forced 0 combinationally.
  - CPU_STALL=1, INSTR=0, MEM_A=0, MEM_WD=LD_DATA.
- Reset mid-load or mid-fill aborts the operation. Memory contents are undefined afterwards; the next load rewrites all 256 locations (load plus fill).
- Load of N bytes (1<=N<=255), one accept per cycle: N accept cycles, then 256-N FILL cycles, then 1 VECTOR cycle. RUN, with BOOT_VALID=1, starts the following cycle.
- Load of N=256: 256 accept cycles, then VECTOR, then RUN. No FILL cycles.
- LD_VALID gaps stretch LOAD by the gap length only.
- Same-cycle RELOAD and BOOT_VALID (first RUN cycle): the reload takes effect. BOOT_VALID still pulses that cycle.
- Fetch latency in RUN: 0 cycles, since INSTR is combinational from PC.

## Test plan
- Reset, then bytes 0x10,0xA5,0x3C with LAST on 0x3C -> MEM[0..2]=10,A5,3C and MEM[3..255]=0 after 253 FILL cycles. Then BOOT_PC=0x10, BOOT_VALID one cycle, CPU_STALL falls; LOAD_CNT=3, OVF=0.
- In RUN, sweep PC=0,1,2,3 -> INSTR=10,A5,3C,00 same cycle. Drive LD_VALID=1 in RUN -> MEM_WE stays 0 and memory is unchanged.
- Stream 256 bytes (value = address XOR 0x55) without LAST -> OVF=1, LOAD_CNT=256, no FILL cycles, BOOT_PC=0x55. A 257th byte is not accepted (LD_READY=0).
- Single byte 0x07 with LAST, then RELOAD in RUN -> CPU_STALL=1 next cycle, LOAD_CNT=0. Reload 0x20,0x99 -> BOOT_PC=0x20, MEM[2..255]=0.
- Assert RST mid-FILL (wr_ptr=0x80) -> outputs reach reset values immediately, MEM_WE=0 during reset. A full reload completes correctly.
- Loader with random LD_VALID gaps, program 0x40,0x01,0x02 with LAST -> same memory image and BOOT_PC=0x40 as the gapless case; RELOAD pulses during LOAD/FILL are ignored.
